// File: rtl/mc_datapath_if.sv
// mc_datapath_if: bus between the multicycle datapath and its single
// instruction/data memory.
//   Adr       datapath -> memory  access address (fetch or load/store)
//   WriteData datapath -> memory  store data
//   ReadData  memory -> datapath  read data
//   MemReady  memory -> datapath  current access has completed
interface mc_datapath_if;
  logic [31:0] Adr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        MemReady;

  modport master (output Adr, output WriteData, input ReadData, input MemReady);
  modport slave  (input Adr, input WriteData, output ReadData, output MemReady);
endinterface

// File: rtl/mc_datapath.sv
// mc_datapath: multicycle ARM-subset datapath driven by an external
// controller FSM. One memory port is shared by fetch and load/store. The
// non-architectural registers (Instr, Data, A, WD, ALUOut) carry values
// between the 3-5 cycles of an instruction. MemReady low stalls every
// state element.
//
// Optional feature: define MC_DATAPATH_SHIFTER_EN to enable the imm8
// rotator (ImmSrc = 00) and the WD barrel shifter (ALUSrcB = 00).
//
// Ports
//   clk, reset                 clock, async active-high reset
//   PCWrite, AdrSrc, IRWrite   PC load, address select, Instr load
//   RegSrc[1:0], RegWrite      register-file read selects, write enable
//   ImmSrc[1:0]                immediate format
//   ALUSrcA, ALUSrcB[1:0]      ALU operand selects
//   ALUControl[2:0]            ALU operation
//   ResultSrc[1:0]             Result select
//   bus                        memory port (Adr, WriteData, ReadData, MemReady)
//   Instr[31:0]                instruction register, to the controller
//   ALUFlags[3:0]              {N,Z,C,V} of the current ALU result
//   Stall                      = ~MemReady
module mc_datapath #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               PCWrite,
  input  logic               AdrSrc,
  input  logic               IRWrite,
  input  logic [1:0]         RegSrc,
  input  logic               RegWrite,
  input  logic [1:0]         ImmSrc,
  input  logic               ALUSrcA,
  input  logic [1:0]         ALUSrcB,
  input  logic [2:0]         ALUControl,
  input  logic [1:0]         ResultSrc,
  mc_datapath_if.master      bus,
  output logic [31:0]        Instr,
  output logic [3:0]         ALUFlags,
  output logic               Stall
);

  logic [31:0] r_pc, r_instr, r_data, r_a, r_wd, r_alu_out;
  logic [31:0] r_rf [0:14];

  logic        w_stall;
  logic [3:0]  w_ra1, w_ra2, w_wa;
  logic [31:0] w_rd1, w_rd2;
  logic [31:0] w_imm8, w_ext_imm, w_wd_sh;
  logic [31:0] w_src_a, w_src_b, w_b_eff, w_alu_result, w_result;
  logic [32:0] w_sum;
  logic        w_sub, w_carry, w_ovf;

  assign w_stall = ~bus.MemReady;

  // R15 reads as PC + 4: PC has already advanced past the instruction
  // during fetch, so this is the instruction address + 8.
  assign w_ra1 = RegSrc[0] ? 4'hF : r_instr[19:16];
  assign w_ra2 = RegSrc[1] ? r_instr[15:12] : r_instr[3:0];
  assign w_wa  = r_instr[15:12];
  assign w_rd1 = (w_ra1 == 4'hF) ? r_pc + 32'd4 : r_rf[w_ra1];
  assign w_rd2 = (w_ra2 == 4'hF) ? r_pc + 32'd4 : r_rf[w_ra2];

`ifdef MC_DATAPATH_SHIFTER_EN
  function automatic logic [31:0] f_ror(input logic [31:0] v, input logic [4:0] s);
    // s == 0 is handled separately so the left shift never reaches 32.
    if (s == 5'd0) return v;
    return (v >> s) | (v << (6'd32 - {1'b0, s}));
  endfunction

  function automatic logic [31:0] f_shift(input logic [31:0] v, input logic [4:0] s,
                                          input logic [1:0] t);
    if (s == 5'd0) return v;
    case (t)
      2'b00:   return v << s;
      2'b01:   return v >> s;
      2'b10:   return 32'($signed(v) >>> s);
      default: return f_ror(v, s);
    endcase
  endfunction

  assign w_imm8  = f_ror({24'd0, r_instr[7:0]}, {r_instr[11:8], 1'b0});
  assign w_wd_sh = f_shift(r_wd, r_instr[11:7], r_instr[6:5]);
`else
  assign w_imm8  = {24'd0, r_instr[7:0]};
  assign w_wd_sh = r_wd;
`endif

  always_comb begin
    case (ImmSrc)
      2'b00:   w_ext_imm = w_imm8;
      2'b01:   w_ext_imm = {20'd0, r_instr[11:0]};
      default: w_ext_imm = {{6{r_instr[23]}}, r_instr[23:0], 2'b00};
    endcase
  end

  assign w_src_a = ALUSrcA ? r_pc : r_a;

  always_comb begin
    case (ALUSrcB)
      2'b00:   w_src_b = w_wd_sh;
      2'b01:   w_src_b = w_ext_imm;
      default: w_src_b = 32'd4;
    endcase
  end

  // Subtract is A + ~B + 1, so the carry-out is the ARM not-borrow.
  assign w_sub   = (ALUControl == 3'b001);
  assign w_b_eff = w_sub ? ~w_src_b : w_src_b;
  assign w_sum   = {1'b0, w_src_a} + {1'b0, w_b_eff} + {32'd0, w_sub};

  always_comb begin
    w_alu_result = w_src_b;
    w_carry      = 1'b0;
    w_ovf        = 1'b0;
    case (ALUControl)
      3'b000, 3'b001: begin
        w_alu_result = w_sum[31:0];
        w_carry      = w_sum[32];
        w_ovf        = (w_src_a[31] == w_b_eff[31]) && (w_sum[31] != w_src_a[31]);
      end
      3'b010:  w_alu_result = w_src_a & w_src_b;
      3'b011:  w_alu_result = w_src_a | w_src_b;
      3'b100:  w_alu_result = w_src_a ^ w_src_b;
      default: w_alu_result = w_src_b;
    endcase
  end

  assign ALUFlags = {w_alu_result[31], (w_alu_result == 32'd0), w_carry, w_ovf};

  always_comb begin
    case (ResultSrc)
      2'b01:   w_result = r_data;
      2'b10:   w_result = w_alu_result;
      default: w_result = r_alu_out;
    endcase
  end

  assign bus.Adr       = AdrSrc ? w_result : r_pc;
  assign bus.WriteData = r_wd;
  assign Instr         = r_instr;
  assign Stall         = w_stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc      <= RESET_PC;
      r_instr   <= 32'd0;
      r_data    <= 32'd0;
      r_a       <= 32'd0;
      r_wd      <= 32'd0;
      r_alu_out <= 32'd0;
    end else if (!w_stall) begin
      r_a       <= w_rd1;
      r_wd      <= w_rd2;
      r_alu_out <= w_alu_result;
      r_data    <= bus.ReadData;
      if (PCWrite) r_pc    <= w_result;
      if (IRWrite) r_instr <= bus.ReadData;
    end
  end

  // The register file has no reset; writes are blocked while reset is
  // held so an aborted instruction cannot retire. Index 15 is the PC.
  always_ff @(posedge clk) begin
    if (!reset && !w_stall && RegWrite && (w_wa != 4'hF))
      r_rf[w_wa] <= w_result;
  end

endmodule

// File: tb/tb_mc_datapath.sv
module tb_mc_datapath;
  localparam logic [31:0] RPC = 32'h0000_0100;
  localparam int S_ADR = 0, S_IR = 1, S_FLG = 2, S_WD = 3, S_STL = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        PCWrite, AdrSrc, IRWrite, RegWrite, ALUSrcA;
  logic [1:0]  RegSrc, ImmSrc, ALUSrcB, ResultSrc;
  logic [2:0]  ALUControl;
  logic [31:0] Instr;
  logic [3:0]  ALUFlags;
  logic        Stall;

  mc_datapath_if bus();

  mc_datapath #(.RESET_PC(RPC)) dut (
    .clk(clk), .reset(reset), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite),
    .RegSrc(RegSrc), .RegWrite(RegWrite), .ImmSrc(ImmSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .ResultSrc(ResultSrc), .bus(bus),
    .Instr(Instr), .ALUFlags(ALUFlags), .Stall(Stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          sel;
    logic [31:0] val;
    string       nm;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] got;
  int          n_checks = 0;
  int          n_err = 0;

  // Monitor: every expectation queued during a cycle is compared against
  // the DUT outputs at the falling edge of that cycle.
  always @(negedge clk) begin
    while (sb.size() != 0) begin
      mon_e = sb.pop_front();
      case (mon_e.sel)
        S_ADR:   got = bus.Adr;
        S_IR:    got = Instr;
        S_FLG:   got = {28'd0, ALUFlags};
        S_WD:    got = bus.WriteData;
        default: got = {31'd0, Stall};
      endcase
      n_checks++;
      if (got !== mon_e.val) begin
        n_err++;
        $display("FAIL %s: got %h expected %h", mon_e.nm, got, mon_e.val);
      end
    end
  end

  task automatic push(input int sel, input logic [31:0] v, input string nm);
    exp_t e;
    e.sel = sel;
    e.val = v;
    e.nm  = nm;
    sb.push_back(e);
  endtask

  task automatic set_def();
    PCWrite = 0; AdrSrc = 0; IRWrite = 0; RegSrc = 0; RegWrite = 0; ImmSrc = 0;
    ALUSrcA = 0; ALUSrcB = 0; ALUControl = 0; ResultSrc = 0;
    bus.MemReady = 1; bus.ReadData = 0;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
    set_def();
  endtask

  task automatic fetch(input logic [31:0] word);
    nxt();
    ALUSrcA = 1; ALUSrcB = 2'b10; ResultSrc = 2'b10; PCWrite = 1; IRWrite = 1;
    bus.ReadData = word;
  endtask

  task automatic load_ir(input logic [31:0] word);
    nxt();
    IRWrite = 1;
    bus.ReadData = word;
  endtask

  // Writes a register through the load path: Instr names Rd, Data captures
  // the value, then ResultSrc = 01 writes it back.
  task automatic wr_reg(input logic [3:0] rd, input logic [31:0] v);
    load_ir({16'd0, rd, 12'd0});
    nxt();
    bus.ReadData = v;
    nxt();
    ResultSrc = 2'b01; RegWrite = 1;
  endtask

  task automatic show_alu(input logic [2:0] op);
    nxt();
    ALUControl = op; AdrSrc = 1; ResultSrc = 2'b10;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] exp_asr, exp_rot;
`ifdef MC_DATAPATH_SHIFTER_EN
    exp_asr = 32'hF800_0000;
    exp_rot = 32'hFF00_0000;
`else
    exp_asr = 32'h8000_0000;
    exp_rot = 32'h0000_00FF;
`endif
    set_def();
    repeat (2) @(posedge clk);
    #1;
    AdrSrc = 1; bus.MemReady = 0;
    push(S_ADR, 32'd0, "rst_aluout");
    push(S_STL, 32'd1, "rst_stall");
    push(S_FLG, 32'h4, "rst_flags");
    push(S_IR, 32'd0, "rst_instr");

    nxt(); reset = 0;
    push(S_ADR, RPC, "rst_pc");
    push(S_STL, 32'd0, "rst_nostall");

    fetch(32'hE3A0_1005);
    push(S_ADR, RPC, "fetch_adr");
    nxt();
    push(S_ADR, 32'h104, "fetch_pc");
    push(S_IR, 32'hE3A0_1005, "fetch_ir");

    wr_reg(4'd1, 32'd5);
    wr_reg(4'd2, 32'd7);
    load_ir(32'h0001_0002);
    nxt();
    show_alu(3'b000);
    push(S_ADR, 32'd12, "add_res");
    push(S_FLG, 32'h0, "add_flags");
    push(S_WD, 32'd7, "add_wd");
    nxt(); AdrSrc = 1;
    push(S_ADR, 32'd12, "add_aluout");
    show_alu(3'b001);
    push(S_ADR, 32'hFFFF_FFFE, "sub_neg_res");
    push(S_FLG, 32'h8, "sub_neg_flags");

    wr_reg(4'd2, 32'd5);
    load_ir(32'h0001_0002);
    nxt();
    show_alu(3'b001);
    push(S_ADR, 32'd0, "sub_eq_res");
    push(S_FLG, 32'h6, "sub_eq_flags");
    show_alu(3'b010);
    push(S_ADR, 32'd5, "and_res");
    push(S_FLG, 32'h0, "and_flags");
    show_alu(3'b100);
    push(S_ADR, 32'd0, "eor_res");
    push(S_FLG, 32'h4, "eor_flags");
    show_alu(3'b011);
    push(S_ADR, 32'd5, "orr_res");

    wr_reg(4'd1, 32'h7FFF_FFFF);
    wr_reg(4'd2, 32'd1);
    load_ir(32'h0001_0002);
    nxt();
    show_alu(3'b000);
    push(S_ADR, 32'h8000_0000, "add_ovf_res");
    push(S_FLG, 32'h9, "add_ovf_flags");
    show_alu(3'b001);
    push(S_ADR, 32'h7FFF_FFFE, "sub_c_res");
    push(S_FLG, 32'h2, "sub_c_flags");

    load_ir(32'h0000_3040);
    show_alu(3'b111); ALUSrcB = 2'b01; ImmSrc = 2'b01;
    push(S_ADR, 32'h40, "imm12");
    nxt(); AdrSrc = 1; bus.ReadData = 32'hDEAD_BEEF;
    push(S_ADR, 32'h40, "ld_adr");
    nxt(); AdrSrc = 1; ResultSrc = 2'b01; RegWrite = 1;
    push(S_ADR, 32'hDEAD_BEEF, "ld_data");
    nxt(); RegSrc = 2'b10;
    nxt();
    push(S_WD, 32'hDEAD_BEEF, "ld_r3");

    for (int i = 0; i < 3; i++) begin
      fetch(32'hCAFE_0001); bus.MemReady = 0;
      push(S_STL, 32'd1, "stall_flag");
      push(S_ADR, 32'h104, "stall_pc_hold");
      push(S_IR, 32'h0000_3040, "stall_ir_hold");
    end
    fetch(32'hCAFE_0001);
    push(S_STL, 32'd0, "stall_release");
    nxt();
    push(S_ADR, 32'h108, "stall_pc_once");
    push(S_IR, 32'hCAFE_0001, "stall_ir_once");

    nxt(); RegSrc = 2'b01;
    nxt(); ALUSrcB = 2'b10; AdrSrc = 1; ResultSrc = 2'b10;
    push(S_ADR, 32'h110, "r15_read");

    load_ir(32'h0AFF_FFFE);
    nxt(); ALUSrcA = 1; ImmSrc = 2'b10; ALUSrcB = 2'b01; ResultSrc = 2'b10;
    AdrSrc = 1; PCWrite = 1;
    push(S_ADR, 32'h100, "branch_tgt");
    push(S_FLG, 32'h2, "branch_flags");
    nxt();
    push(S_ADR, 32'h100, "branch_pc");

    wr_reg(4'd2, 32'h8000_0000);
    load_ir(32'h0000_0242);
    nxt();
    show_alu(3'b111);
    push(S_ADR, exp_asr, "asr4");
    push(S_WD, 32'h8000_0000, "asr_wd");
    load_ir(32'h0000_0062);
    nxt();
    show_alu(3'b111);
    push(S_ADR, 32'h8000_0000, "ror0");

    fetch(32'h0000_04FF);
    show_alu(3'b111); ALUSrcB = 2'b01; ImmSrc = 2'b00;
    push(S_ADR, exp_rot, "imm_rot");

    nxt(); ALUSrcA = 1; ALUSrcB = 2'b10; AdrSrc = 1;
    #2 reset = 1;
    push(S_ADR, 32'd0, "async_aluout");
    push(S_IR, 32'd0, "async_ir");
    nxt();
    push(S_ADR, RPC, "async_pc");
    nxt(); reset = 0;
    push(S_ADR, RPC, "post_rst_fetch");

    nxt();
    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/mc_datapath.md
# mc_datapath

Multicycle successor to the single-cycle ARM datapath: one unified memory port shared by fetch and load/store, with architectural and non-architectural state registers (PC, Instr, Data, A, WD, ALUOut) so each instruction spans 3–5 cycles under an external multicycle controller FSM. It adds a memory-ready stall and an optional operand barrel shifter. It sits between the multicycle controller and a single instruction/data memory.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- PCWrite  in  1  load PC from Result.
- AdrSrc  in  1  Adr select: 0 = PC, 1 = Result.
- IRWrite  in  1  load Instr register from ReadData.
- RegSrc  in  2  [0]: RA1 = R15; [1]: RA2 = Instr[15:12].
- RegWrite  in  1  write Result to Instr[15:12].
- ImmSrc  in  2  00 = zero-extended imm8 (rotated when shifter enabled), 01 = zero-extended imm12, 10 = sign-extended imm24<<2.
- ALUSrcA  in  1  0 = A register, 1 = PC.
- ALUSrcB  in  2  00 = WD register (shifted when shifter enabled), 01 = ExtImm, 10 = constant 4.
- ALUControl  in  3  000 ADD, 001 SUB, 010 AND, 011 ORR, 100 EOR, others pass SrcB.
- ResultSrc  in  2  00 = ALUOut, 01 = Data, 10 = ALUResult, 11 = ALUOut.
- MemReady  in  1  memory has completed the current access.
- ReadData  in  32  memory read data.
- Instr  out  32  instruction register contents, to the controller.
- ALUFlags  out  4  {N,Z,C,V} of the current ALUResult.
- Adr  out  32  memory address.
- WriteData  out  32  WD register, store data.
- Stall  out  1  = ~MemReady.

## Operation
- Register file: R0–R14 with no reset. R15 reads return PC + 4. PC has already advanced in fetch, so this equals the instruction address + 8. Writes to index 15 are ignored; PC is written only via PCWrite.
- RA1 = RegSrc[0] ? 4'hF : Instr[19:16]. RA2 = RegSrc[1] ? Instr[15:12] : Instr[3:0].
- When not stalled, every cycle: A ← rd1, WD ← rd2, ALUOut ← ALUResult, Data ← ReadData.
- Enable-gated writes, also suppressed by Stall:
  - PC ← Result on PCWrite.
  - Instr ← ReadData on IRWrite.
  - Regfile write on RegWrite.
- Stall (MemReady = 0): all state registers and the register file hold. Combinational outputs still follow held state.
- ALU: 32-bit.
  - N = Result[31]; Z = (Result == 0).
  - ADD: C = carry-out; V = signed overflow.
  - SUB: A + ~B + 1; C = not-borrow; V = signed overflow.
  - Logic ops and pass: C = V = 0.
- Reset values: PC = RESET_PC; Instr, Data, A, WD, ALUOut = 0; Stall follows MemReady.

## Timing
- All state updates on the rising edge of clk, except reset, which clears asynchronously.
- Adr, ALUFlags, and Result are combinational from the current state registers and control inputs in the same cycle.
- Register-file read is combinational. A written register is visible on rd1/rd2 the cycle after the write edge; no internal bypass.
- A load takes effect one cycle after the memory access: Data is captured at the edge where MemReady = 1, then written back using ResultSrc = 01.
- Reset asserted mid-instruction discards all in-flight state. The first fetch after reset deasserts is at RESET_PC.
- A simultaneous Stall and PCWrite/IRWrite/RegWrite always resolves to hold.

## Configuration
- MC_DATAPATH_SHIFTER_EN defined:
  - For ImmSrc = 00, ExtImm = imm8 rotated right by 2×Instr[11:8].
  - For ALUSrcB = 00, SrcB = WD shifted by shamt5 = Instr[11:7] with sh = Instr[6:5] (00 LSL, 01 LSR, 10 ASR, 11 ROR).
  - shamt 0 means no shift for every type.
- Undefined: no rotation or shift; SrcB = WD and ExtImm = zero-extended imm8 directly.

## Test plan
- Reset with RESET_PC = 32'h100, then release → Adr = 32'h100 and Instr = 0. Drive a fetch step (ALUSrcA = 1, ALUSrcB = 10, ResultSrc = 10, PCWrite = 1, IRWrite = 1) → PC = 32'h104 and Instr = ReadData.
- ADD: R1 = 5, R2 = 7, ALUControl = 000 → ALUOut = 12 and flags 0000. SUB with R1 = R2 = 5 → flags 0110 (Z = 1, C = 1).
- Load: Adr = ALUOut = 32'h40, ReadData = 32'hDEAD_BEEF, then ResultSrc = 01 with RegWrite to R3 → a later read of R3 returns 32'hDEADBEEF.
- Hold MemReady = 0 for 3 cycles during a fetch with PCWrite = 1 → PC and Instr unchanged and Stall = 1. After MemReady = 1, a single update occurs.
- Assert reset asynchronously mid-cycle during an execute step → PC = RESET_PC and ALUOut = 0 before the next clock edge.
- With MC_DATAPATH_SHIFTER_EN defined, R2 = 32'h8000_0000 shifted ASR #4 → SrcB = 32'hF800_0000. Immediate imm8 = 8'hFF with rot = 4 → ExtImm = 32'hFF00_0000.
